// File: rtl/uart_result_arbiter.sv
// uart_result_arbiter: round-robin sharing of one UART_TX between 16-bit result producers.
// Define UART_ARB_TAG_EN to prefix each word with a tag byte {4'hA, 2'b00, grant_id}.
module uart_result_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ena,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  word_in,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   uart_start,
    output logic [7:0]             uart_data,
    input  logic                   uart_busy,
    output logic [1:0]             grant_id,
    output logic                   active,
    output logic                   done,
    output logic                   timeout_err
);

    localparam logic [7:0] TIMEOUT   = 8'(START_TIMEOUT);
    localparam logic [1:0] LAST_INIT = 2'(NUM_REQ - 1);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [2:0] {
        IDLE, SEND_TAG, WAIT_TAG, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO
    } state_t;
    localparam state_t FIRST = SEND_TAG;
`else
    typedef enum logic [2:0] {
        IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO
    } state_t;
    localparam state_t FIRST = SEND_HI;
`endif

    state_t               state_q, state_d;
    state_t               wait_nx;
    logic [7:0]           cnt_q, cnt_d, cnt_inc;
    logic [15:0]          word_q, word_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           last_q, last_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 done_q, done_d;
    logic                 to_q, to_d;
    logic                 is_send;

    logic [15:0]          words [NUM_REQ];
    logic [3:0]           req4;
    logic [1:0]           idx;
    logic [1:0]           pick;
    logic                 hit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = word_in[16*i +: 16];
        end
    end

    // first requester above the previous grant, wrapping modulo NUM_REQ
    always_comb begin
        req4 = 4'(req);
        hit  = 1'b0;
        pick = '0;
        idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 2'((int'(last_q) + k) % NUM_REQ);
            if (!hit && req4[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 8'd1;
        word_d  = word_q;
        grant_d = grant_q;
        last_d  = last_q;
        ack_d   = '0;
        done_d  = 1'b0;
        to_d    = 1'b0;
        is_send = 1'b0;
        wait_nx = IDLE;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    word_d  = words[pick];
                    grant_d = pick;
                    last_d  = pick;
                    ack_d   = NUM_REQ'(4'b0001 << pick);
                    cnt_d   = '0;
                    state_d = FIRST;
                end
            end
`ifdef UART_ARB_TAG_EN
            SEND_TAG: begin
                is_send = 1'b1;
                wait_nx = WAIT_TAG;
            end
            WAIT_TAG: begin
                if (!uart_busy) state_d = SEND_HI;
            end
`endif
            SEND_HI: begin
                is_send = 1'b1;
                wait_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (!uart_busy) state_d = SEND_LO;
            end
            SEND_LO: begin
                is_send = 1'b1;
                wait_nx = WAIT_LO;
            end
            WAIT_LO: begin
                if (!uart_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // busy seen while strobing is acceptance, even on the first cycle
        if (is_send) begin
            if (uart_busy) begin
                state_d = wait_nx;
                cnt_d   = '0;
            end else if (cnt_inc == TIMEOUT) begin
                state_d = IDLE;
                cnt_d   = '0;
                to_d    = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            grant_q <= '0;
            last_q  <= LAST_INIT;
            ack_q   <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        uart_data = 8'h00;
        case (state_q)
`ifdef UART_ARB_TAG_EN
            SEND_TAG, WAIT_TAG: uart_data = {4'hA, 2'b00, grant_q};
`endif
            SEND_HI, WAIT_HI: uart_data = word_q[15:8];
            SEND_LO, WAIT_LO: uart_data = word_q[7:0];
            default:          uart_data = 8'h00;
        endcase
    end

    // pulses freeze with the FSM and reappear once ena returns
    assign uart_start  = ena && is_send;
    assign ack         = ena ? ack_q : '0;
    assign done        = ena && done_q;
    assign timeout_err = ena && to_q;
    assign grant_id    = grant_q;
    assign active      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_result_arbiter.sv
// tb_uart_result_arbiter: randomized self-checking bench for uart_result_arbiter.
// A behavioural UART model and a queue-based arbitration/byte-stream model predict results.
module tb_uart_result_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int START_TIMEOUT = 15;
    localparam int BUSY_LEN      = 10;
`ifdef UART_ARB_TAG_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic                  clock     = 1'b0;
    logic                  reset     = 1'b1;
    logic                  ena       = 1'b1;
    logic                  uart_busy = 1'b0;
    logic [NUM_REQ-1:0]    req       = '0;
    logic [16*NUM_REQ-1:0] word_in   = '0;
    logic [NUM_REQ-1:0]    ack;
    logic                  uart_start;
    logic [7:0]            uart_data;
    logic [1:0]            grant_id;
    logic                  active;
    logic                  done;
    logic                  timeout_err;

    int checks   = 0;
    int failures = 0;

    bit         tie0 = 1'b0;
    bit         pend = 1'b0;
    int         bcnt = 0;
    int         viol = 0;
    logic [7:0] rx[$];
    logic [7:0] eb[$];
    int         gq[$];
    int         ackn[NUM_REQ];
    int         dones = 0;
    int         touts = 0;

    always #5 clock = ~clock;

    uart_result_arbiter #(
        .NUM_REQ(NUM_REQ),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ena(ena),
        .req(req),
        .word_in(word_in),
        .ack(ack),
        .uart_start(uart_start),
        .uart_data(uart_data),
        .uart_busy(uart_busy),
        .grant_id(grant_id),
        .active(active),
        .done(done),
        .timeout_err(timeout_err)
    );

    // UART_TX model: busy rises one cycle after start is seen, stays BUSY_LEN cycles
    always @(negedge clock) begin
        if (tie0) begin
            uart_busy = 1'b0;
            pend      = 1'b0;
            bcnt      = 0;
        end else if (pend) begin
            if (!uart_start) viol++;
            pend      = 1'b0;
            uart_busy = 1'b1;
            bcnt      = BUSY_LEN;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) uart_busy = 1'b0;
        end else if (uart_start && !uart_busy) begin
            rx.push_back(uart_data);
            pend = 1'b1;
        end
    end

    function automatic int next_grant(input int last, input logic [3:0] m);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (m[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic void push_word(input int g, input logic [15:0] w);
        logic [1:0] g2;
        g2 = 2'(g);
`ifdef UART_ARB_TAG_EN
        eb.push_back({4'hA, 2'b00, g2});
`endif
        eb.push_back(w[15:8]);
        eb.push_back(w[7:0]);
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ena   = 1'b1;
        req   = '0;
        tie0  = 1'b0;
        step();
        for (int c = 0; c < 60 && (uart_busy || pend); c++) step();
        step();
        reset = 1'b0;
    endtask

    task automatic serve(input int n, input bit drop);
        int dn;
        dn = 0;
        for (int c = 0; c < 4000 && dn < n; c++) begin
            step();
            if (ack != '0) begin
                gq.push_back(int'(grant_id));
                for (int i = 0; i < NUM_REQ; i++) ackn[i] += int'(ack[i]);
                if (drop) req = req & ~ack;
            end
            if (timeout_err) touts++;
            if (done) begin
                dn++;
                dones++;
                if (dn == n) req = '0;
            end
        end
        checks++;
        if (dn != n) begin
            failures++;
            $display("FAIL serve_bound done_seen=%0d required=%0d", dn, n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs [7];
        string      nm  [7];
        reset   = 1'b1;
        req     = '1;
        word_in = {4{16'hFFFF}};
        step();
        step();
        obs = '{8'(ack), 8'(uart_start), uart_data, 8'(grant_id),
                8'(active), 8'(done), 8'(timeout_err)};
        nm  = '{"ack", "uart_start", "uart_data", "grant_id",
                "active", "done", "timeout_err"};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_%s got=%h required=00", nm[i], obs[i]);
            end
        end
        req   = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int rb, gb, v0, d0, a0, t0;
        do_reset();
        word_in        = '0;
        word_in[15:0]  = 16'h12AB;
        rb = rx.size(); gb = gq.size(); v0 = viol;
        d0 = dones; a0 = ackn[0]; t0 = touts;
        eb.delete();
        push_word(0, 16'h12AB);
        req = 4'b0001;
        serve(1, 1'b1);
        step();
        checks++;
        if (ackn[0] - a0 != 1) begin
            failures++;
            $display("FAIL single_ack got=%0d required=1", ackn[0] - a0);
        end
        checks++;
        if (gq.size() <= gb || gq[gb] != 0) begin
            failures++;
            $display("FAIL single_grant got=%0d required=0", gq.size() > gb ? gq[gb] : -1);
        end
        checks++;
        if (rx.size() != rb + eb.size()) begin
            failures++;
            $display("FAIL single_nbytes got=%0d required=%0d", rx.size() - rb, eb.size());
        end
        for (int k = 0; k < eb.size(); k++) begin
            if (rb + k < rx.size()) begin
                checks++;
                if (rx[rb+k] !== eb[k]) begin
                    failures++;
                    $display("FAIL single_byte%0d got=%h required=%h", k, rx[rb+k], eb[k]);
                end
            end
        end
        checks++;
        if (viol != v0) begin
            failures++;
            $display("FAIL single_start_hold got=%0d drops required=0", viol - v0);
        end
        checks++;
        if (dones - d0 != 1 || touts != t0) begin
            failures++;
            $display("FAIL single_done got=%0d/%0d required=1/0", dones - d0, touts - t0);
        end
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL single_active_after got=%b required=0", active);
        end
    endtask

    task automatic test_round_robin();
        int rb, gb, last, g, v0;
        int a0 [NUM_REQ];
        int eg [$];
        logic [15:0] w [NUM_REQ];
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            w[i] = 16'($urandom);
            word_in[16*i +: 16] = w[i];
            a0[i] = ackn[i];
        end
        eb.delete();
        last = NUM_REQ - 1;
        for (int k = 0; k < 8; k++) begin
            g = next_grant(last, 4'hF);
            eg.push_back(g);
            push_word(g, w[g]);
            last = g;
        end
        rb = rx.size(); gb = gq.size(); v0 = viol;
        req = 4'b1111;
        serve(8, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (gq.size() <= gb + k || gq[gb+k] != eg[k]) begin
                failures++;
                $display("FAIL rr_grant%0d got=%0d required=%0d", k,
                         gq.size() > gb + k ? gq[gb+k] : -1, eg[k]);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            checks++;
            if (ackn[i] - a0[i] != 2) begin
                failures++;
                $display("FAIL rr_ack%0d got=%0d required=2", i, ackn[i] - a0[i]);
            end
        end
        checks++;
        if (rx.size() != rb + eb.size() || viol != v0) begin
            failures++;
            $display("FAIL rr_nbytes got=%0d required=%0d", rx.size() - rb, eb.size());
        end
        for (int k = 0; k < eb.size(); k++) begin
            if (rb + k < rx.size()) begin
                checks++;
                if (rx[rb+k] !== eb[k]) begin
                    failures++;
                    $display("FAIL rr_byte%0d got=%h required=%h", k, rx[rb+k], eb[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int t, ts, ep, dn, bad_act, bad_start;
        int g   [3];
        int dur [2];
        int eg  [3];
        t = 0; ts = -1; ep = -1; dn = 0; bad_act = 0; bad_start = 0;
        g   = '{-1, -1, -1};
        dur = '{-1, -1};
        eg[0] = next_grant(NUM_REQ - 1, 4'b0011);
        eg[1] = next_grant(eg[0], 4'b0011);
        eg[2] = next_grant(eg[1], 4'b0011);
        do_reset();
        tie0    = 1'b1;
        word_in = {$urandom, $urandom};
        req     = 4'b0011;
        for (int c = 0; c < 400 && ep < 2; c++) begin
            step();
            t++;
            if (ack != '0) begin
                ep++;
                g[ep] = int'(grant_id);
                ts = -1;
            end
            if (uart_start && ts < 0) ts = t;
            if (ep == 1 && ts >= 0 && t == ts + 5) begin
                ena = 1'b0;
                for (int f = 0; f < 20; f++) begin
                    step();
                    if (uart_start !== 1'b0) bad_start++;
                end
                t += 20;
                ena = 1'b1;
            end
            if (timeout_err) begin
                if (ep >= 0 && ep < 2 && ts >= 0) dur[ep] = t - ts;
                if (active) bad_act++;
            end
            if (done) dn++;
        end
        req  = '0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (g[i] != eg[i]) begin
                failures++;
                $display("FAIL timeout_grant%0d got=%0d required=%0d", i, g[i], eg[i]);
            end
        end
        checks++;
        if (dur[0] != START_TIMEOUT) begin
            failures++;
            $display("FAIL timeout_delay got=%0d required=%0d", dur[0], START_TIMEOUT);
        end
        checks++;
        if (dur[1] != START_TIMEOUT + 20) begin
            failures++;
            $display("FAIL timeout_frozen_delay got=%0d required=%0d", dur[1], START_TIMEOUT + 20);
        end
        checks++;
        if (dn != 0 || bad_act != 0 || bad_start != 0) begin
            failures++;
            $display("FAIL timeout_side got done=%0d active=%0d start=%0d required=0/0/0",
                     dn, bad_act, bad_start);
        end
    endtask

    task automatic test_ena();
        int  rb, r1, bad, frozen, fin;
        do_reset();
        word_in       = '0;
        word_in[15:0] = 16'h12AB;
        eb.delete();
        push_word(0, 16'h12AB);
        rb = rx.size(); bad = 0; frozen = 0; fin = 0; r1 = 0;
        req = 4'b0001;
        for (int c = 0; c < 400 && !fin; c++) begin
            step();
            if (ack != '0) req = req & ~ack;
            if (!frozen && rx.size() == rb + NB - 1 && uart_busy && !uart_start) begin
                ena = 1'b0;
                r1  = rx.size();
                for (int f = 0; f < 5; f++) begin
                    step();
                    if (uart_start !== 1'b0 || active !== 1'b1 || done !== 1'b0) bad++;
                end
                if (rx.size() != r1) bad++;
                ena    = 1'b1;
                frozen = 1;
            end
            if (done) fin = 1;
        end
        checks++;
        if (!frozen || !fin || bad != 0) begin
            failures++;
            $display("FAIL ena_freeze got frozen=%0d done=%0d bad=%0d required=1/1/0",
                     frozen, fin, bad);
        end
        checks++;
        if (rx.size() != rb + eb.size()) begin
            failures++;
            $display("FAIL ena_nbytes got=%0d required=%0d", rx.size() - rb, eb.size());
        end
        for (int k = 0; k < eb.size(); k++) begin
            if (rb + k < rx.size()) begin
                checks++;
                if (rx[rb+k] !== eb[k]) begin
                    failures++;
                    $display("FAIL ena_byte%0d got=%h required=%h", k, rx[rb+k], eb[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rb, gb, hit, d0;
        logic [7:0] obs [7];
        do_reset();
        word_in = {$urandom, $urandom};
        rb = rx.size(); hit = 0;
        req = 4'b0100;
        for (int c = 0; c < 300 && !hit; c++) begin
            step();
            if (ack != '0) req = req & ~ack;
            if (uart_start && rx.size() == rb + NB) hit = 1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midreset_reach got=0 required=1");
        end
        d0 = dones;
        reset = 1'b1;
        step();
        obs = '{8'(ack), 8'(uart_start), uart_data, 8'(grant_id),
                8'(active), 8'(done), 8'(timeout_err)};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs[i] !== 8'h00) begin
                failures++;
                $display("FAIL midreset_out%0d got=%h required=00", i, obs[i]);
            end
        end
        for (int c = 0; c < 60 && (uart_busy || pend); c++) begin
            step();
            if (done || timeout_err) d0--;
        end
        reset = 1'b0;
        gb = gq.size();
        req = 4'b1111;
        serve(1, 1'b1);
        checks++;
        if (gq.size() <= gb || gq[gb] != next_grant(NUM_REQ - 1, 4'hF)) begin
            failures++;
            $display("FAIL midreset_next_grant got=%0d required=%0d",
                     gq.size() > gb ? gq[gb] : -1, next_grant(NUM_REQ - 1, 4'hF));
        end
        checks++;
        if (d0 != dones - 1) begin
            failures++;
            $display("FAIL midreset_pulses got=%0d required=%0d", dones - 1, d0);
        end
    endtask

    task automatic test_random();
        int rb, gb, last, g, n;
        logic [3:0]  mask, m;
        logic [15:0] w;
        int eg [$];
        do_reset();
        last = NUM_REQ - 1;
        for (int r = 0; r < 6; r++) begin
            mask    = 4'($urandom_range(1, 15));
            word_in = {$urandom, $urandom};
            eb.delete();
            eg.delete();
            m = mask;
            while (m != 4'b0000) begin
                g = next_grant(last, m);
                w = word_in[16*g +: 16];
                eg.push_back(g);
                push_word(g, w);
                m[g] = 1'b0;
                last = g;
            end
            n  = $countones(mask);
            rb = rx.size(); gb = gq.size();
            req = mask;
            serve(n, 1'b1);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (gq.size() <= gb + k || gq[gb+k] != eg[k]) begin
                    failures++;
                    $display("FAIL rand%0d_grant%0d got=%0d required=%0d", r, k,
                             gq.size() > gb + k ? gq[gb+k] : -1, eg[k]);
                end
            end
            checks++;
            if (rx.size() != rb + eb.size()) begin
                failures++;
                $display("FAIL rand%0d_nbytes got=%0d required=%0d", r, rx.size() - rb, eb.size());
            end
            for (int k = 0; k < eb.size(); k++) begin
                if (rb + k < rx.size()) begin
                    checks++;
                    if (rx[rb+k] !== eb[k]) begin
                        failures++;
                        $display("FAIL rand%0d_byte%0d got=%h required=%h", r, k, rx[rb+k], eb[k]);
                    end
                end
            end
        end
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        int rb;
        logic [7:0] want [3];
        want = '{8'hA2, 8'hBE, 8'hEF};
        do_reset();
        word_in          = '0;
        word_in[47:32]   = 16'hBEEF;
        rb = rx.size();
        req = 4'b0100;
        serve(1, 1'b1);
        checks++;
        if (rx.size() != rb + 3) begin
            failures++;
            $display("FAIL tag_nbytes got=%0d required=3", rx.size() - rb);
        end
        for (int k = 0; k < 3; k++) begin
            if (rb + k < rx.size()) begin
                checks++;
                if (rx[rb+k] !== want[k]) begin
                    failures++;
                    $display("FAIL tag_byte%0d got=%h required=%h", k, rx[rb+k], want[k]);
                end
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NUM_REQ; i++) ackn[i] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ena();
        test_reset_mid();
        test_random();
`ifdef UART_ARB_TAG_EN
        test_tag();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
